// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serializer/deserializer sequencer for an external SI/SO shift register
// Accepts a word, shifts it MSB-first into SI on divided clken pulses, flushes, and captures SO.
module shift_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DIV_W-1:0]  div,
  output logic              sr_si,
  output logic              sr_clken,
  input  logic              sr_so,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int TOTAL = DATA_W + WIDTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT_END = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_CAP_FIRST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_tx;
  logic [DATA_W-1:0]  r_rx;
  logic [DIV_W-1:0]   r_div_q;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_clken;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [DIV_W-1:0]   w_div_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_capture;

  always_comb begin
    w_div_next = (r_div_cnt == '0) ? r_div_q : r_div_cnt - 1'b1;
    w_cnt_next = r_cnt + 1'b1;
    // Enables WIDTH+1 .. WIDTH+DATA_W see the word on SO; earlier ones only push out stale bits.
    w_capture  = (r_cnt >= CNT_CAP_FIRST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_div_q     <= '0;
      r_div_cnt   <= '0;
      r_cnt       <= '0;
      r_clken     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_tx       <= in_data;
            r_div_q    <= div;
            r_div_cnt  <= div;
            r_clken    <= (div == '0);
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end

        S_SHIFT, S_FLUSH: begin
          // clken is registered, so it is computed from the divider value of the next cycle.
          r_div_cnt <= w_div_next;
          r_clken   <= (w_div_next == '0);
          if (r_clken) begin
            r_tx  <= r_tx << 1;
            r_cnt <= w_cnt_next;
            if (w_capture) begin
              r_rx <= (r_rx << 1) | DATA_W'(sr_so);
            end
            if ((r_state == S_SHIFT) && (w_cnt_next == CNT_SHIFT_END)) begin
              r_state <= S_FLUSH;
            end
            if (w_cnt_next == CNT_LAST) begin
              r_state     <= S_DONE;
              r_clken     <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // tx is zero-filled as it shifts, so its MSB is already 0 through FLUSH and IDLE.
  assign sr_si     = r_tx[DATA_W-1];
  assign sr_clken  = r_clken;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_rx;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - bench for shift_seq_ctrl driving a loopback shift register
// Expected values come from the transfer rules: loopback returns the word, enables every d+1 cycles.
module tb_shift_seq_ctrl;

  localparam int W     = 4;
  localparam int DW    = 8;
  localparam int LIMIT = 2000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [7:0]    div;
  logic          sr_si;
  logic          sr_clken;
  logic          sr_so;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  logic [W-1:0]  sr_q;
  logic          load_en;
  logic [W-1:0]  load_val;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [7:0] data;
    logic [7:0] dv;
    logic [3:0] prefill;
    int         hold;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  shift_seq_ctrl #(.WIDTH(W), .DATA_W(DW), .DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .div       (div),
    .sr_si     (sr_si),
    .sr_clken  (sr_clken),
    .sr_so     (sr_so),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External loopback shift register; load port lets the bench plant stale contents.
  always @(posedge clk) begin
    if (load_en) sr_q <= load_val;
    else if (sr_clken) sr_q <= {sr_q[W-2:0], sr_si};
  end
  assign sr_so = sr_q[W-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic prefill(input logic [W-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic do_xfer(input logic [7:0] data, input logic [7:0] d, input int hold,
                         input bit noisy, input int exp_lat, input logic [7:0] exp_data);
    int lat, nen, clk_bad, si_bad, busy_bad, hold_bad, guard;
    logic exp_si;
    logic [7:0] held;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = data;
    div      = d;
    @(posedge clk);
    lat = 0; nen = 0; clk_bad = 0; si_bad = 0; busy_bad = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (noisy) begin
        in_data = 8'($urandom);
        div     = 8'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      if (sr_clken !== ((k % (int'(d) + 1)) == 0)) clk_bad++;
      if (sr_clken) begin
        nen++;
        exp_si = (nen <= DW) ? data[DW-nen] : 1'b0;
        if (sr_si !== exp_si) si_bad++;
      end
      if (!busy || in_ready) busy_bad++;
    end
    in_valid = 1'b0;
    if (lat == 0) $display("FAIL timeout waiting for out_valid");
    check("latency", lat, exp_lat);
    check("enable_count", nen, DW + W);
    check("clken_spacing_errs", clk_bad, 0);
    check("si_sequence_errs", si_bad, 0);
    check("busy_inready_errs", busy_bad, 0);
    check("out_data", out_data, exp_data);
    held = out_data;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || in_ready || sr_clken || !busy) hold_bad++;
    end
    check("done_hold_errs", hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    div       = '0;
    out_ready = 1'b0;
    load_en   = 1'b0;
    load_val  = '0;

    vecs[0] = '{data: 8'hA5, dv: 8'd0, prefill: 4'h0, hold: 0,  exp_data: 8'hA5, exp_lat: 13};
    vecs[1] = '{data: 8'h3C, dv: 8'd2, prefill: 4'h0, hold: 0,  exp_data: 8'h3C, exp_lat: 37};
    vecs[2] = '{data: 8'h00, dv: 8'd1, prefill: 4'hF, hold: 0,  exp_data: 8'h00, exp_lat: 25};
    vecs[3] = '{data: 8'hFF, dv: 8'd0, prefill: 4'h0, hold: 10, exp_data: 8'hFF, exp_lat: 13};
    vecs[4] = '{data: 8'h5A, dv: 8'd5, prefill: 4'hA, hold: 3,  exp_data: 8'h5A, exp_lat: 73};

    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, sr_si, sr_clken, out_valid, busy}, 5'b10000);
    check("reset_out_data", out_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      prefill(vecs[i].prefill);
      do_xfer(vecs[i].data, vecs[i].dv, vecs[i].hold, 1'b0, vecs[i].exp_lat, vecs[i].exp_data);
    end

    // Reset in the middle of a transfer, after five enables.
    begin
      int nen, guard;
      in_valid = 1'b1;
      in_data  = 8'h81;
      div      = 8'd1;
      @(posedge clk);
      nen = 0;
      guard = 0;
      while (nen < 5 && guard < 200) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (sr_clken) nen++;
        guard++;
      end
      @(negedge clk);
      check("midxfer_busy", {busy, in_ready}, 2'b10);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {in_ready, sr_si, sr_clken, out_valid, busy}, 5'b10000);
      check("async_reset_out_data", out_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_xfer(8'h42, 8'd1, 0, 1'b0, 25, 8'h42);
    end

    // Producer keeps presenting new words and dividers while a transfer runs.
    do_xfer(8'h96, 8'd1, 2, 1'b1, 25, 8'h96);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] rd;
      logic [7:0] rdv;
      rd  = 8'($urandom);
      rdv = 8'($urandom_range(0, 4));
      prefill(4'($urandom));
      do_xfer(rd, rdv, $urandom_range(0, 3), r[0], (DW + W) * (int'(rdv) + 1) + 1, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the team's serial-in/serial-out shift register (SI, SO, clken; MSB of the register is SO).
- Accepts a parallel word on a valid/ready handshake and generates a rate-divided clken stream. Drives the word into SI MSB-first, then flushes the register.
- Captures the word returning on SO into a parallel result, presented on a second valid/ready handshake.
- Sits between a parallel producer/consumer and one external shift-register instance (loopback or a serial delay line).

Parameters:
- WIDTH, 4, length of the controlled shift register (stages between SI and SO); must be ≥2.
- DATA_W, 8, bits per transferred word; must be ≥1.
- DIV_W, 8, width of the clock-enable divider setting.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  word to serialize.
- div  in  DIV_W  enable period minus one; sampled at accept.
- sr_si  out  1  drives shift register SI.
- sr_clken  out  1  drives shift register clken; single-cycle pulses.
- sr_so  in  1  shift register SO.
- out_valid  out  1  captured word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured word, MSB first off SO.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready=1; sr_si=0; sr_clken=0; out_valid=0; out_data=0; busy=0; all counters 0. The external register is not reset by this block.
- States: IDLE, SHIFT, FLUSH, DONE. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch in_data into tx register and div into div_q; load divider with div_q; bit counter=0; go to SHIFT.
- Divider:
  - Active in SHIFT/FLUSH; counts down each cycle.
  - When it reads 0: sr_clken=1 for that cycle, and the divider reloads div_q.
  - Enables are spaced div_q+1 cycles apart. The first enable occurs div_q+1 cycles after the accept edge. div_q=0 gives back-to-back enables.
- SHIFT:
  - sr_si = tx[DATA_W-1].
  - On each enable edge: tx shifts left by 1 (zero fill) and enable count increments.
  - After DATA_W enables, go to FLUSH.
- FLUSH:
  - sr_si=0.
  - After WIDTH more enables (DATA_W+WIDTH total), go to DONE.
- Capture:
  - On enable number m (1-based), for WIDTH+1 ≤ m ≤ WIDTH+DATA_W, at the enable edge: rx = {rx[DATA_W-2:0], sr_so}.
  - Stale register contents are fully flushed before the first capture. In loopback, out_data == in_data regardless of the prior register state.
- DONE:
  - out_valid=1 and out_data=rx, held stable until out_ready.
  - On out_valid&out_ready: out_valid=0, go to IDLE. in_ready rises the cycle after.
  - in_ready=0 throughout SHIFT/FLUSH/DONE, so no accept is possible while a result is pending.
- sr_clken=0 in IDLE and DONE.
- div changes after accept have no effect on the current transfer.
- Enable count is $clog2(DATA_W+WIDTH+1) bits wide; no wrap.
- rst_n asserted mid-transfer: immediate return to reset values; the partial word is discarded.
- Latency with div_q=d: out_valid rises (DATA_W+WIDTH)·(d+1)+1 cycles after the accept edge.

Test Plan:
1. WIDTH=4, DATA_W=8, div=0, loopback (controller drives a shift_register instance, SO→sr_so), in_data=0xA5 → sr_clken high for cycles 1..12 after accept; sr_si sequence 1,0,1,0,0,1,0,1,0,0,0,0; out_valid at cycle 13; out_data=0xA5.
2. div=2, in_data=0x3C → clken pulses every 3rd cycle, 12 pulses; out_valid at cycle 37; out_data=0x3C.
3. Pre-fill the register with 1111, then send in_data=0x00 → out_data=0x00 (stale bits flushed).
4. out_ready held low 10 cycles in DONE → out_valid and out_data stable, in_ready=0, no clken. out_ready=1 → IDLE; next word 0xFF is accepted and returns 0xFF.
5. rst_n pulsed low after 5 enables of 0x81 → all outputs return to reset values asynchronously. A new word 0x42 then returns exactly 0x42.
6. in_valid held high during SHIFT with changing in_data and div → ignored; the transfer completes with the originally accepted word and divider.
